// File: rtl/mips_data_sram_bridge.sv
// rtl/mips_data_sram_bridge.sv - M-stage data port to sram-like req/ack bus bridge
// Turns one load/store strobe into a single handshaked bus transaction and stalls until it completes.
module mips_data_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memreadM,
  input  logic                memwriteM,
  input  logic [ADDR_W-1:0]   aluoutM,
  input  logic [DATA_W-1:0]   writedataM,
  input  logic [DATA_W/8-1:0] selectM,
  input  logic                flushM,
  input  logic                stall_other,
  output logic [DATA_W-1:0]   readdataM,
  output logic                stall_dmem,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LOW  = SEL_W'({(SEL_W/2){1'b1}});
  localparam logic [SEL_W-1:0] SEL_HIGH = SEL_LOW << (SEL_W / 2);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateT;

  stateT             state;
  stateT             stateNext;
  logic              acc;
  logic              reqLive;
  logic              curWr;
  logic [1:0]        curSize;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curWdata;
  logic              captureRd;

  logic              wrQ;
  logic [1:0]        sizeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rdataQ;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space.
  function automatic logic [ADDR_W-1:0] mapAddr(input logic [ADDR_W-1:0] va);
    logic [ADDR_W-1:0] pa;
    pa = va;
    if (va[ADDR_W-1 -: 2] == 2'b10) pa[ADDR_W-1 -: 3] = 3'b000;
    return pa;
  endfunction

  function automatic logic [1:0] sizeOf(input logic [SEL_W-1:0] sel);
    logic [1:0] sz;
    if (sel == '1)                                       sz = 2'd2;
    else if (sel == SEL_LOW || sel == SEL_HIGH)          sz = 2'd1;
    else if (sel != '0 && (sel & (sel - SEL_ONE)) == '0) sz = 2'd0;
    else                                                 sz = 2'd2;
    return sz;
  endfunction

  // Reset also gates the request so a core still asserting memreadM cannot leak onto the bus.
  always_comb begin
    acc     = (memreadM | memwriteM) & ~flushM & rst;
    reqLive = ((state == IDLE) & acc) | (state == ADDR);
    if (state == IDLE) begin
      curWr    = memwriteM;
      curSize  = sizeOf(selectM);
      curAddr  = mapAddr(aluoutM);
      curWdata = writedataM;
    end else begin
      curWr    = wrQ;
      curSize  = sizeQ;
      curAddr  = addrQ;
      curWdata = wdataQ;
    end
    data_req   = reqLive;
    data_wr    = reqLive & curWr;
    data_size  = curSize;
    data_addr  = curAddr;
    data_wdata = curWdata;
    stall_dmem = reqLive | (state == DATA);
    readdataM  = rdataQ;
    captureRd  = ((reqLive & data_addr_ok & data_data_ok) |
                  ((state == DATA) & data_data_ok)) & ~curWr;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (acc) begin
          if (data_addr_ok) stateNext = data_data_ok ? DONE : DATA;
          else              stateNext = ADDR;
        end
      end
      ADDR: begin
        if (data_addr_ok) stateNext = data_data_ok ? DONE : DATA;
      end
      DATA: begin
        if (data_data_ok) stateNext = DONE;
      end
      DONE: begin
        // Leaving DONE coincides with the pipeline advance, so the access is never reissued.
        if (!stall_other) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wrQ    <= 1'b0;
      sizeQ  <= 2'd0;
      addrQ  <= '0;
      wdataQ <= '0;
      rdataQ <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && acc) begin
        wrQ    <= memwriteM;
        sizeQ  <= curSize;
        addrQ  <= curAddr;
        wdataQ <= writedataM;
      end
      if (captureRd) rdataQ <= data_rdata;
    end
  end

endmodule
